// File: rtl/pwm_deadtime_driver.sv
// Complementary high-side/low-side gate driver with dead-time insertion and a latched fault.
// Outputs are registered and decoded from the next state, so they change on the same edge as the state.
module pwm_deadtime_driver #(
    parameter int DEAD_CYCLES = 2,
    parameter int CNT_W       = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic pwm_in,
    input  logic fault_in,
    input  logic fault_clr,
    output logic hs_out,
    output logic ls_out,
    output logic fault_latched
);

    typedef enum logic [2:0] {
        IDLE,
        DT_HS,
        HS_ON,
        DT_LS,
        LS_ON,
        FAULT
    } state_t;

    localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYCLES - 1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             pwm_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            pwm_q         <= 1'b0;
            hs_out        <= 1'b0;
            ls_out        <= 1'b0;
            fault_latched <= 1'b0;
        end else begin
            state         <= state_next;
            cnt           <= cnt_next;
            pwm_q         <= pwm_in;
            hs_out        <= (state_next == HS_ON);
            ls_out        <= (state_next == LS_ON);
            fault_latched <= (state_next == FAULT);
        end
    end

    // Fault beats enable, enable beats normal sequencing; a pwm reversal during dead time restarts the count.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        if (fault_in) begin
            state_next = FAULT;
            cnt_next   = '0;
        end else if (state == FAULT) begin
            if (fault_clr) begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        end else if (!enable) begin
            state_next = IDLE;
            cnt_next   = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_next = pwm_q ? DT_HS : DT_LS;
                    cnt_next   = '0;
                end
                LS_ON: begin
                    if (pwm_q) begin
                        state_next = DT_HS;
                        cnt_next   = '0;
                    end
                end
                HS_ON: begin
                    if (!pwm_q) begin
                        state_next = DT_LS;
                        cnt_next   = '0;
                    end
                end
                DT_HS: begin
                    if (!pwm_q) begin
                        state_next = DT_LS;
                        cnt_next   = '0;
                    end else if (cnt == DEAD_LAST) begin
                        state_next = HS_ON;
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end
                DT_LS: begin
                    if (pwm_q) begin
                        state_next = DT_HS;
                        cnt_next   = '0;
                    end else if (cnt == DEAD_LAST) begin
                        state_next = LS_ON;
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end
                default: begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_deadtime_driver.sv
// Directed bench for pwm_deadtime_driver with DEAD_CYCLES=2; each scenario drives one input per cycle
// (changed at the falling edge) and compares outputs 1 ns after the following rising edge.
module tb_pwm_deadtime_driver;

    logic clk;
    logic rst_n;
    logic enable;
    logic pwm_in;
    logic fault_in;
    logic fault_clr;
    logic hs_out;
    logic ls_out;
    logic fault_latched;

    int n_checks = 0;
    int n_fail   = 0;

    pwm_deadtime_driver #(
        .DEAD_CYCLES(2),
        .CNT_W      (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .pwm_in       (pwm_in),
        .fault_in     (fault_in),
        .fault_clr    (fault_clr),
        .hs_out       (hs_out),
        .ls_out       (ls_out),
        .fault_latched(fault_latched)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Both gates high at once would short the half-bridge.
    always @(negedge clk) begin
        n_checks++;
        if (hs_out === 1'b1 && ls_out === 1'b1) begin
            n_fail++;
            $display("[TB] FAIL overlap at %0t: hs=%b ls=%b, required not both 1", $time, hs_out, ls_out);
        end
    end

    task automatic drive_cycle(input logic p, input logic en, input logic f, input logic c);
        @(negedge clk);
        pwm_in    = p;
        enable    = en;
        fault_in  = f;
        fault_clr = c;
        @(posedge clk);
        #1;
    endtask

    task automatic go_idle(input logic level);
        repeat (3) drive_cycle(level, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        rst_n     = 1'b1;
        enable    = 1'b0;
        pwm_in    = 1'b0;
        fault_in  = 1'b0;
        fault_clr = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (hs_out !== 1'b0 || ls_out !== 1'b0 || fault_latched !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_async hs=%b ls=%b fl=%b, required 0 0 0", hs_out, ls_out, fault_latched);
        end
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (hs_out !== 1'b0 || ls_out !== 1'b0 || fault_latched !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_hold hs=%b ls=%b fl=%b, required 0 0 0", hs_out, ls_out, fault_latched);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_duty(input string name, input string p, input string eh, input string el, input logic pre);
        logic exp_h;
        logic exp_l;
        go_idle(pre);
        for (int k = 0; k < p.len(); k++) begin
            drive_cycle(p[k] == "1", 1'b1, 1'b0, 1'b0);
            exp_h = (eh[k] == "1");
            exp_l = (el[k] == "1");
            n_checks++;
            if (hs_out !== exp_h || ls_out !== exp_l) begin
                n_fail++;
                $display("[TB] FAIL %s k=%0d hs=%b ls=%b, required hs=%b ls=%b", name, k, hs_out, ls_out, exp_h, exp_l);
            end
        end
    endtask

    task automatic test_fault();
        string f  = "00000101000000";
        string c  = "00000001010000";
        string eh = "00011000000011";
        string ef = "00000111100000";
        logic  exp_h;
        logic  exp_f;
        go_idle(1'b0);
        for (int k = 0; k < 14; k++) begin
            drive_cycle(1'b1, 1'b1, f[k] == "1", c[k] == "1");
            exp_h = (eh[k] == "1");
            exp_f = (ef[k] == "1");
            n_checks++;
            if (hs_out !== exp_h || ls_out !== 1'b0 || fault_latched !== exp_f) begin
                n_fail++;
                $display("[TB] FAIL fault k=%0d hs=%b ls=%b fl=%b, required hs=%b ls=0 fl=%b",
                         k, hs_out, ls_out, fault_latched, exp_h, exp_f);
            end
        end
    endtask

    task automatic test_enable_toggle();
        string en = "111110111111";
        string eh = "000110001111";
        logic  exp_h;
        go_idle(1'b0);
        for (int k = 0; k < 12; k++) begin
            drive_cycle(1'b1, en[k] == "1", 1'b0, 1'b0);
            exp_h = (eh[k] == "1");
            n_checks++;
            if (hs_out !== exp_h || ls_out !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL enable_toggle k=%0d hs=%b ls=%b, required hs=%b ls=0", k, hs_out, ls_out, exp_h);
            end
        end
    endtask

    task automatic test_async_reset();
        string el = "0011";
        logic  exp_l;
        go_idle(1'b0);
        for (int k = 0; k < 4; k++) begin
            drive_cycle(1'b0, 1'b1, 1'b0, 1'b0);
            exp_l = (el[k] == "1");
            n_checks++;
            if (ls_out !== exp_l || hs_out !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL pre_reset k=%0d hs=%b ls=%b, required hs=0 ls=%b", k, hs_out, ls_out, exp_l);
            end
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (ls_out !== 1'b0 || hs_out !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL midcycle_reset hs=%b ls=%b, required 0 0", hs_out, ls_out);
        end
        for (int k = 0; k < 3; k++) begin
            drive_cycle(1'b0, 1'b1, 1'b0, 1'b0);
            n_checks++;
            if (ls_out !== 1'b0 || hs_out !== 1'b0 || fault_latched !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL reset_held k=%0d hs=%b ls=%b fl=%b, required 0 0 0", k, hs_out, ls_out, fault_latched);
            end
        end
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive_cycle(1'b0, 1'b1, 1'b0, 1'b0);
            exp_l = (el[k] == "1");
            n_checks++;
            if (ls_out !== exp_l || hs_out !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL post_reset k=%0d hs=%b ls=%b, required hs=0 ls=%b", k, hs_out, ls_out, exp_l);
            end
        end
    endtask

    initial begin
        test_reset();
        test_duty("duty5",
                  "111110000011111000001111100000",
                  "000111000000011100000001110000",
                  "000000001110000000111000000011", 1'b0);
        test_duty("duty1",
                  "100000000010000000001000000000",
                  "000000000000000000000000000000",
                  "000011111110001111111000111111", 1'b0);
        test_duty("duty3",
                  "111000000011100000001110000000",
                  "000100000000010000000001000000",
                  "000000111110000011111000001111", 1'b0);
        test_duty("duty10",
                  "111111111111111",
                  "000111111111111",
                  "000000000000000", 1'b0);
        test_duty("duty0",
                  "000000000000000",
                  "000000000000000",
                  "000111111111111", 1'b1);
        test_fault();
        test_enable_toggle();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pwm_deadtime_driver.md
Name: pwm_deadtime_driver

Overview:
- Downstream stage of the push-button PWM generator.
- Takes the single-ended PWM output (10-clock period, duty 0..10 tenths) and produces a complementary high-side/low-side gate-drive pair with programmable dead time.
- Latches a shoot-through/overcurrent fault that forces both outputs off until software or button clearing.
- Sits between the PWM generator and the FPGA pins that drive the half-bridge.

Parameters:
- DEAD_CYCLES, 2, number of clk cycles both outputs are held low between one output falling and the other rising; legal range 1..15.
- CNT_W, 4, width of the dead-time counter; must hold DEAD_CYCLES-1.

Ports:
- clk  in  1  system clock (100 MHz), same clock as the PWM generator.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  1 = drive outputs; 0 = force both outputs off (non-fault states return to IDLE).
- pwm_in  in  1  PWM signal from the generator, synchronous to clk.
- fault_in  in  1  external fault (overcurrent/shoot-through sense), synchronous, active-high.
- fault_clr  in  1  single-cycle pulse to leave FAULT.
- hs_out  out  1  high-side gate drive, registered.
- ls_out  out  1  low-side gate drive, registered.
- fault_latched  out  1  1 while in FAULT, registered.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE, pwm_q=0, cnt=0.
  - hs_out=0, ls_out=0, fault_latched=0.
- Input stage: pwm_q <= pwm_in every edge. The FSM uses pwm_q only.
- States and outputs (all outputs registered, decoded from next state):
  - IDLE: hs=0, ls=0.
  - DT_HS: hs=0, ls=0.
  - HS_ON: hs=1, ls=0.
  - DT_LS: hs=0, ls=0.
  - LS_ON: hs=0, ls=1.
  - FAULT: hs=0, ls=0, fault_latched=1.
- Priority each edge: fault_in, then enable=0, then normal transitions.
- fault_in=1 from any state goes to FAULT. Both outputs are 0 after that same edge.
- FAULT exits to IDLE only when fault_clr=1 and fault_in=0 at the same edge. fault_clr while fault_in=1 is ignored.
- enable=0 from any non-FAULT state goes to IDLE and sets cnt=0.
- IDLE (enable=1): goes to DT_HS if pwm_q=1, else DT_LS; cnt=0.
- LS_ON: pwm_q=1 goes to DT_HS, cnt=0.
- HS_ON: pwm_q=0 goes to DT_LS, cnt=0.
- DT_HS:
  - If pwm_q=0, go to DT_LS with cnt=0. Reversal takes priority over completion.
  - Else if cnt==DEAD_CYCLES-1, go to HS_ON.
  - Else cnt+1.
- DT_LS: mirror of DT_HS, with pwm_q=1 reversing to DT_HS and completion going to LS_ON.
- Timing:
  - Each dead-time state lasts exactly DEAD_CYCLES cycles unless reversed.
  - Latency from the edge where pwm_in is sampled high to hs_out rising is 1+DEAD_CYCLES edges. The same latency applies from pwm_in low to ls_out rising.
- Pulse widths:
  - A pwm high pulse of H cycles gives an hs_out pulse of H-DEAD_CYCLES cycles when H>DEAD_CYCLES.
  - Pulses with H<=DEAD_CYCLES are swallowed; the same holds for low pulses and ls_out.
- Invariant: hs_out & ls_out == 0 in every cycle, including around reset, fault and enable toggles.
- Reset mid-operation: both outputs drop asynchronously. After release the FSM restarts from IDLE, so a full dead time precedes any output.
- Constant pwm_in (duty 0% or 100%): after the initial dead time, the matching output stays high continuously.

Test Plan:
- DEAD_CYCLES=2; pwm period 10, duty 5 (high 5, low 5) -> hs_out high 3 cycles, 2 dead, ls_out high 3 cycles, 2 dead, repeating with period 10. Each hs_out rise is 3 edges after the pwm_in rise; overlap never seen.
- DEAD_CYCLES=2; duty 1 (high 1, low 9) -> hs_out never rises; ls_out high 7 cycles per period. Duty 3 -> hs_out high exactly 1 cycle per period.
- Duty 10 (pwm_in constant 1) after reset -> hs_out=0 for 3 cycles after enable, then constantly 1; ls_out constantly 0. Duty 0 -> mirror on ls_out.
- fault_in pulsed 1 cycle while hs_out=1:
  - hs_out=0 and fault_latched=1 after that edge.
  - A fault_clr sent with fault_in=1 is ignored.
  - fault_clr with fault_in=0 -> IDLE, then a full 2-cycle dead time precedes the next output.
- enable dropped for 1 cycle mid-HS_ON -> both outputs 0 next cycle. On re-enable, dead time restarts and hs_out returns 1+2 edges later.
- rst_n asserted asynchronously mid-cycle during LS_ON -> ls_out falls immediately, without waiting for a clock edge. All outputs stay 0 until release, then IDLE behaviour as above.
- A checker asserts !(hs_out && ls_out) throughout all scenarios.
